bin_packer: RTL and testbench

Downstream stage of the adaptive-threshold engine. Consumes the serial one-bit-per-pixel binarized stream and the per-block threshold, then packs each 8-pixel row of an 8x8 block into a byte. Each byte is tagged with its result-memory address and block threshold and buffered in a small FIFO. The FIFO drains to the result-memory writer over a valid/ready handshake.

---
 rtl/ate_pkg.sv | 18 +
 rtl/sync_fifo.sv | 41 ++++
 rtl/bin_packer.sv | 79 +++++++
 tb/tb_bin_packer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ate_pkg.sv
// ate_pkg: constants and the packed row-entry type shared across the adaptive-threshold engine.
package ate_pkg;
    localparam int BLK_PIX      = 64;
    localparam int ROW_PIX      = 8;
    localparam int ROWS_PER_BLK = 8;
    localparam int ADDR_MAX     = 16;

    typedef struct packed {
        logic [7:0]          data;
        logic [ADDR_MAX-1:0] addr;
        logic [7:0]          thr;
        logic                last;
    } entry_t;

    function automatic int addr_bits(input int num_blocks);
        return $clog2(ROWS_PER_BLK * num_blocks);
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO; a push while full is taken only together with a pop.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && count != '0;
    assign do_push = push && (!full || do_pop);
    // Empty FIFO presents zeros so the head never shows a stale entry
    assign dout    = count == '0 ? '0 : mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= (do_push && !do_pop) ? count + 1'b1 :
                     (!do_push && do_pop) ? count - 1'b1 : count;
        end
endmodule

// File: rtl/bin_packer.sv
// bin_packer: packs each 8-pixel row of a binarized 8x8 block into a byte tagged with
// its result address and block threshold, buffered in a FWFT FIFO towards the memory writer.
module bin_packer
    import ate_pkg::*;
#(
    parameter int NUM_BLOCKS = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = addr_bits(NUM_BLOCKS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_bin,
    input  logic [7:0]        in_thr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_thr,
    output logic              out_last,
    output logic              overflow
);
    localparam int BW = NUM_BLOCKS > 1 ? $clog2(NUM_BLOCKS) : 1;

    logic [5:0]                    pix_idx;
    logic [BW-1:0]                 blk_idx;
    logic [7:0]                    sr, thr_q;
    logic [2:0]                    row;
    logic                          col_end, blk_end, pop, full;
    logic [$clog2(FIFO_DEPTH):0]   count;
    entry_t                        entry, head;
    logic                          spare_unused;

    assign row     = pix_idx[5:3];
    assign col_end = in_valid && pix_idx[2:0] == 3'(ROW_PIX - 1);
    assign blk_end = in_valid && pix_idx == 6'(BLK_PIX - 1);
    assign pop     = out_valid && out_ready;

    // thr_q is already loaded from pixel 0 by the time any row word is pushed
    always_comb begin
        entry.data = {sr[6:0], in_bin};
        entry.addr = ADDR_MAX'({blk_idx, row});
        entry.thr  = thr_q;
        entry.last = blk_idx == BW'(NUM_BLOCKS - 1) && row == 3'(ROWS_PER_BLK - 1);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pix_idx  <= '0;
            blk_idx  <= '0;
            sr       <= '0;
            thr_q    <= '0;
            overflow <= 1'b0;
        end else if (in_valid) begin
            pix_idx <= pix_idx + 1'b1;
            sr      <= {sr[6:0], in_bin};
            if (pix_idx == '0) thr_q <= in_thr;
            if (blk_end) blk_idx <= blk_idx == BW'(NUM_BLOCKS - 1) ? '0 : blk_idx + 1'b1;
            if (col_end && full && !pop) overflow <= 1'b1;
        end

    sync_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (col_end),
        .pop   (pop),
        .din   (entry),
        .dout  (head),
        .full  (full),
        .count (count)
    );

    assign out_valid    = count != '0;
    assign out_data     = head.data;
    assign out_addr     = head.addr[ADDR_W-1:0];
    assign out_thr      = head.thr;
    assign out_last     = head.last;
    assign spare_unused = ^{head.addr, sr[7]};
endmodule

// File: tb/tb_bin_packer.sv
// tb_bin_packer: directed and randomized stimulus checked against a pixel-position reference model.
module tb_bin_packer;
    localparam int NB    = 6;
    localparam int DEPTH = 4;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bin = 1'b0;
    logic [7:0]    in_thr = 8'h00;
    logic          out_ready = 1'b0;
    logic          out_valid, out_last, overflow;
    logic [7:0]    out_data, out_thr;
    logic [AW-1:0] out_addr;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int data;
        int addr;
        int thr;
        int last;
    } exp_t;

    exp_t q[$];
    int   beats;
    int   m_thr;
    int   m_ovf;
    bit   pix[64];

    always #5 clk = ~clk;

    bin_packer #(.NUM_BLOCKS(NB), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bin    (in_bin),
        .in_thr    (in_thr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_thr   (out_thr),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (beat %0d)", tag, obs, exp, beats);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), (q.size() != 0) ? 32'd1 : 32'd0);
        if (q.size() != 0) begin
            chk("out_data", 32'(out_data), q[0].data);
            chk("out_addr", 32'(out_addr), q[0].addr);
            chk("out_thr", 32'(out_thr), q[0].thr);
            chk("out_last", 32'(out_last), q[0].last);
        end
        chk("overflow", 32'(overflow), m_ovf);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare
    task automatic step(input bit v, input bit b, input int t, input bit r);
        int   p;
        int   rw;
        int   word;
        exp_t e;
        in_valid  = v;
        in_bin    = b;
        in_thr    = 8'(t);
        out_ready = r;
        @(posedge clk);
        if (q.size() != 0 && r) void'(q.pop_front());
        if (v) begin
            p = beats % 64;
            if (p == 0) m_thr = t;
            pix[p] = b;
            if (p % 8 == 7) begin
                rw   = p / 8;
                word = 0;
                for (int c = 0; c < 8; c++) word = word * 2 + int'(pix[rw * 8 + c]);
                e.data = word;
                e.addr = ((beats / 64) % NB) * 8 + rw;
                e.thr  = m_thr;
                e.last = (e.addr == NB * 8 - 1) ? 1 : 0;
                if (q.size() < DEPTH) q.push_back(e);
                else m_ovf = 1;
            end
            beats++;
        end
        #1;
        check_outputs();
    endtask

    // kind: 0 alternating 1,0 / 1 all ones / 2 random; thr < 0 picks a random block threshold
    task automatic run_beats(input int n, input int thr, input int kind, input int gap_pct, input int rdy_pct);
        int done;
        int p;
        int t;
        bit b;
        done = 0;
        while (done < n) begin
            if ($urandom_range(99) < gap_pct) begin
                step(1'b0, 1'($urandom), int'($urandom_range(255)), $urandom_range(99) < rdy_pct);
            end else begin
                p = beats % 64;
                t = (p == 0) ? ((thr < 0) ? int'($urandom_range(255)) : thr) : int'($urandom_range(255));
                b = (kind == 0) ? (p % 2 == 0) : (kind == 1) ? 1'b1 : 1'($urandom);
                step(1'b1, b, t, $urandom_range(99) < rdy_pct);
                done++;
            end
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock
    task automatic hard_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        beats = 0;
        m_thr = 0;
        m_ovf = 0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_addr", 32'(out_addr), 32'd0);
        chk("rst_thr", 32'(out_thr), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        hard_reset();
        run_beats(64, 8'h5A, 0, 0, 100);

        hard_reset();
        for (int b = 0; b < NB; b++) run_beats(64, 8'h10 + b, 1, 0, 100);
        run_beats(64, 8'h77, 2, 0, 100);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1);

        hard_reset();
        run_beats(40, 8'h21, 2, 0, 0);
        chk("overflow_after_5_rows", 32'(overflow), 32'd1);
        run_beats(60, 8'h22, 2, 0, 100);

        hard_reset();
        run_beats(32, 8'h33, 2, 0, 0);
        run_beats(7, 8'h33, 2, 0, 0);
        run_beats(1, 8'h33, 2, 0, 100);
        chk("full_pop_no_overflow", 32'(overflow), 32'd0);
        run_beats(8, 8'h33, 2, 0, 0);
        run_beats(40, 8'h34, 2, 0, 100);

        hard_reset();
        run_beats(900, -1, 2, 30, 60);
        run_beats(200, -1, 2, 30, 100);

        hard_reset();
        run_beats(2 * 64 + 29, -1, 2, 10, 100);
        run_beats(8, -1, 2, 0, 0);
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        hard_reset();
        run_beats(64, 8'hC3, 2, 20, 100);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
